// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Multiplication is a 32-step shift-add and division a 32-step restoring
// shift-subtract, both on unsigned magnitudes. A single negate flag fixes up
// the sign at the end. The pipeline is held through stallreq until the
// registered one-cycle ready strobe.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            annul,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            stallreq
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Latched operation context
    logic [2:0]        f3_reg;
    logic [XLEN-1:0]   opnd_reg;   // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_reg;    // product accumulator or remainder:quotient pair
    logic              neg_reg;    // final two's-complement fix-up
    logic [CW-1:0]     cnt_reg;

    logic [XLEN-1:0]   result_reg, result_next;
    logic              ready_reg, ready_next;

    // ------------------------------------------------------------------
    // Operand decode (evaluated on the ID/EX operands while in IDLE)
    // ------------------------------------------------------------------
    logic            is_div;
    logic            div_zero;
    logic [1:0]      opnd_signed;
    logic [XLEN-1:0] opnd_in  [2];
    logic [XLEN-1:0] opnd_mag [2];
    logic [1:0]      opnd_neg;
    logic            neg_start;
    logic [XLEN-1:0] dz_result;

    assign is_div   = func3[2];
    assign div_zero = is_div && (op_b == '0);

    // op_a is signed for MULH, MULHSU, DIV, REM; op_b for MULH, DIV, REM.
    // MUL is treated as unsigned: the low half of the product is identical.
    assign opnd_signed[0] = (func3 == F_MULH) || (func3 == F_MULHSU) ||
                            (func3 == F_DIV)  || (func3 == F_REM);
    assign opnd_signed[1] = (func3 == F_MULH) || (func3 == F_DIV) ||
                            (func3 == F_REM);
    assign opnd_in[0] = op_a;
    assign opnd_in[1] = op_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mag
            assign opnd_neg[gi] = opnd_signed[gi] & opnd_in[gi][XLEN-1];
            assign opnd_mag[gi] = opnd_neg[gi] ? (~opnd_in[gi] + 1'b1) : opnd_in[gi];
        end
    endgenerate

    // Remainder takes the dividend's sign; every other result takes the
    // product/quotient sign.
    assign neg_start = (is_div && func3[1]) ? opnd_neg[0] : (opnd_neg[0] ^ opnd_neg[1]);

    // Divide by zero: all-ones quotient, dividend as remainder, any signedness.
    assign dz_result = func3[1] ? op_a : '1;

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] step;

    // Shift-add: the multiplier sits in the low half and drains out to the
    // right while the partial product grows in from the top.
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                      (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring division: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The difference is below the divisor,
    // so the low XLEN bits of the subtraction are exact.
    assign rem_sh   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_ge   = rem_sh >= {1'b0, opnd_reg};
    assign div_diff = rem_sh[XLEN-1:0] - opnd_reg;
    assign div_step = div_ge ? {div_diff, acc_reg[XLEN-2:0], 1'b1}
                             : {rem_sh[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};

    assign step = f3_reg[2] ? div_step : mul_step;

    // ------------------------------------------------------------------
    // Sign fix-up and result selection on the final iteration
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_sel;

    assign prod_fix = neg_reg ? (~step + 1'b1) : step;
    assign quo_fix  = neg_reg ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
    assign rem_fix  = neg_reg ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];

    // Pick the architectural result for the latched operation
    always_comb begin
        final_sel = prod_fix[XLEN-1:0];
        case (f3_reg)
            F_MUL:                      final_sel = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  final_sel = prod_fix[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              final_sel = quo_fix;
            F_REM, F_REMU:              final_sel = rem_fix;
            default:                    final_sel = prod_fix[XLEN-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // Next state plus the value registered into result/ready on entry to DONE,
    // so the strobe is visible during the DONE cycle itself.
    always_comb begin
        state_next  = state_reg;
        ready_next  = 1'b0;
        result_next = result_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && !annul) begin
                    if (div_zero) begin
                        state_next  = S_DONE;
                        ready_next  = 1'b1;
                        result_next = dz_result;
                    end else begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (annul || !start) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == CW'(XLEN-1)) begin
                    state_next  = S_DONE;
                    ready_next  = 1'b1;
                    result_next = final_sel;
                end
            end
            S_DONE: begin
                // start is still high here for the same instruction; ignore it.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, result and completion strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            ready_reg  <= ready_next;
        end
    end

    // Datapath: capture the operation in IDLE, iterate in CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_reg   <= '0;
            opnd_reg <= '0;
            acc_reg  <= '0;
            neg_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !annul) begin
                        f3_reg  <= func3;
                        neg_reg <= neg_start;
                        cnt_reg <= '0;
                        if (is_div) begin
                            opnd_reg <= opnd_mag[1];
                            acc_reg  <= {{XLEN{1'b0}}, opnd_mag[0]};
                        end else begin
                            opnd_reg <= opnd_mag[0];
                            acc_reg  <= {{XLEN{1'b0}}, opnd_mag[1]};
                        end
                    end
                end
                S_CALC: begin
                    acc_reg <= step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

    assign result   = result_reg;
    assign ready    = ready_reg;
    assign stallreq = start & ~annul & (state_reg != S_DONE) & ~rst;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and random checks of ex_muldiv against an arithmetic
// reference model (64-bit integer multiply/divide with RISC-V rules).
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic        annul;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        ready;
    logic        stallreq;

    int          n_checks;
    int          n_err;
    logic [31:0] last_res;

    ex_muldiv #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .annul    (annul),
        .func3    (func3),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (result),
        .ready    (ready),
        .stallreq (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          ps;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned pu;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (f3)
            3'd0: begin pu = ua * ub; r = pu[31:0]; end
            3'd1: begin ps = sa * sb; r = ps[63:32]; end
            3'd2: begin ps = sa * longint'(ub); r = ps[63:32]; end
            3'd3: begin pu = ua * ub; r = pu[63:32]; end
            3'd4: begin if (b == 0) r = 32'hFFFF_FFFF; else begin ps = sa / sb; r = ps[31:0]; end end
            3'd5: begin if (b == 0) r = 32'hFFFF_FFFF; else begin pu = ua / ub; r = pu[31:0]; end end
            3'd6: begin if (b == 0) r = a; else begin ps = sa % sb; r = ps[31:0]; end end
            default: begin if (b == 0) r = a; else begin pu = ua % ub; r = pu[31:0]; end end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one M instruction starting in the current cycle (called #1 after a
    // posedge) and follow it to completion. Leaves start high and returns #1
    // after the edge that ends the ready cycle, so a following call is a
    // back-to-back instruction.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected);
        int exp_lat;
        int lat;
        int stall_cnt;
        bit got;
        logic stall_at_ready;
        exp_lat = (f3[2] && b == 32'd0) ? 1 : 33;
        start = 1'b1;
        func3 = f3;
        op_a  = a;
        op_b  = b;
        got = 1'b0;
        lat = 0;
        stall_cnt = 0;
        stall_at_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stallreq) stall_cnt++;
            if (ready) begin
                got = 1'b1;
                lat = c;
                stall_at_ready = stallreq;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_ready_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({tag, "_stall_at_ready"}, 32'(stall_at_ready), 32'd0);
        check({tag, "_result"}, result, expected);
        $display("op %s f3=%0d a=%h b=%h result=%h expected=%h latency=%0d", tag, f3, a, b,
                 result, expected, lat);
        last_res = expected;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_err    = 0;
        last_res = '0;
        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        func3 = '0;
        op_a  = '0;
        op_b  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_stallreq", 32'(stallreq), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Multiply
        do_op("mul", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        idle(1);
        do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        idle(1);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        idle(1);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(1);

        // Divide
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        idle(1);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        idle(1);
        do_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        idle(1);
        do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
        idle(1);

        // Corner cases
        do_op("div_by0", 3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        idle(1);
        do_op("remu_by0", 3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678);
        idle(1);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        idle(1);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        idle(1);
        do_op("remu_pre_annul", 3'd7, 32'd100, 32'd7, 32'd2);
        idle(1);

        // Annul at N+10: no strobe, result held, IDLE again at N+11 so a
        // start seen there completes a full 33 cycles later.
        start = 1'b1;
        func3 = 3'd5;
        op_a  = 32'd1000;
        op_b  = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("annul_pre_ready", 32'(ready), 32'd0);
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(negedge clk);
        check("annul_stallreq", 32'(stallreq), 32'd0);
        check("annul_ready", 32'(ready), 32'd0);
        check("annul_result_held", result, last_res);
        $display("annul asserted result=%h", result);
        @(posedge clk);
        #1;
        annul = 1'b0;
        do_op("after_annul", 3'd5, 32'd1000, 32'd7, 32'd142);
        idle(1);

        // Asynchronous reset between edges at N+20
        start = 1'b1;
        func3 = 3'd0;
        op_a  = 32'd11;
        op_b  = 32'd13;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_result", result, 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_stallreq", 32'(stallreq), 32'd0);
        $display("mid-op reset result=%h ready=%0d stallreq=%0d", result, ready, stallreq);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15);
        idle(1);

        // Back-to-back with start held across the pipeline advance
        do_op("b2b_mul", 3'd0, 32'd3, 32'd5, 32'd15);
        do_op("b2b_divu", 3'd5, 32'd15, 32'd5, 32'd3);
        idle(2);

        // Random operations against the model, some back-to-back
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = rand_opnd();
            rb  = rand_opnd();
            do_op($sformatf("rand%0d", i), rf3, ra, rb, model(rf3, ra, rb));
            if ($urandom_range(0, 1) == 0) idle(1);
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and func3 that the ID/EX pipeline register presents. It computes all eight M-extension operations over multiple cycles and raises a stall request to the pipeline controller so that PC, IF/ID and ID/EX freeze until the result is ready. The EX result mux selects `result` when `ready` is high.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.

- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: EX holds an M-extension instruction (opcode 0110011, func7 0000001). Held high for the whole stall.
- `annul` in 1: cancel the in-flight operation (flush). Synchronous.
- `func3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in 32: rs1 value (ex_reg1).
- `op_b` in 32: rs2 value (ex_reg2).
- `result` out 32: final value. Valid when `ready` is high, then held until the next completion.
- `ready` out 1: one-cycle completion strobe (registered).
- `stallreq` out 1: combinational stall request to the pipeline controller.

## Operation
- States are IDLE, CALC and DONE.
- **IDLE**
  - When `start` is high and `annul` is low, latch `func3`.
  - Latch magnitudes |op_a| and |op_b|. Signed interpretation depends on func3:
    - MULH: both operands signed.
    - MULHSU: op_a signed only.
    - DIV/REM: both operands signed.
  - Latch a negate flag:
    - MUL*: sign(a) XOR sign(b).
    - DIV quotient: sign(a) XOR sign(b).
    - REM: sign(a).
  - Clear the 5-bit iteration counter.
  - Division by zero (func3[2]=1, op_b=0) goes directly to DONE. Any other operation goes to CALC.
- **CALC**, one iteration per cycle, 32 iterations:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 64-bit remainder:quotient pair.
  - When the counter reaches 31, go to DONE.
- **DONE**
  - Apply the negate flag (two's complement).
  - Select the output:
    - MUL: low 32 bits of the product.
    - MULH/MULHSU/MULHU: high 32 bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selection into `result` and pulse `ready`. Return to IDLE next cycle unconditionally. `start` is ignored in DONE, so the same instruction is never restarted.
- **Special cases**
  - Divide by zero: quotient 0xFFFFFFFF, remainder = op_a, for both signed and unsigned.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of the magnitude/negate path and needs no extra logic.
- **Stall request:** `stallreq = start & ~annul & (state != DONE) & ~rst`.
- **Abort:** `annul` high, or `start` low in CALC, sends CALC to IDLE next edge. No `ready` pulse; `result` keeps its previous value.
- **Reset:**
  - `rst` high at any time forces IDLE asynchronously.
  - `result`=0, `ready`=0, counter=0, `stallreq`=0.

## Timing
- `start` is first seen in IDLE in cycle N.
  - CALC occupies cycles N+1 to N+32.
  - `ready`=1 and `result` are valid in cycle N+33.
  - `stallreq` is high in cycles N to N+32 (33 stall cycles) and low in N+33, so the pipeline advances at the end of N+33.
- Divide by zero: `stallreq` is high in cycle N only. `ready` is high in N+1.
- Back-to-back M instructions: the second `start` is seen in IDLE in cycle N+34. No bubble is needed beyond the pipeline advance.
- `ready` is never high for two consecutive cycles.
- `ready` never appears after an abort or reset.

## Test plan
- **Multiply:**
  - MUL 0x00000007 × 0xFFFFFFFD -> `result`=0xFFFFFFEB at N+33, `stallreq` high for exactly 33 cycles.
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- **Divide:**
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU 100 / 7 -> 2.
- **Corner cases:**
  - DIV 0x12345678 / 0 -> 0xFFFFFFFF with `ready` at N+1.
  - REMU 0x12345678 / 0 -> 0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- **Annul:** start DIVU, assert `annul` at cycle N+10 -> state IDLE at N+11, `stallreq` low during annul, no `ready` pulse, `result` unchanged.
- **Reset mid-operation:** assert `rst` asynchronously at N+20 (between edges) -> `result`=0, `ready`=0 and `stallreq`=0 immediately. After release, a new MUL 3×5 gives 15 at 33 cycles post-start.
- **Back-to-back:** MUL 3×5 then DIVU 15/5 with `start` kept high across the advance -> `ready` pulses at N+33 (15) and N+67 (3). `stallreq` is low only in N+33 between them.
